// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter; display reads always win over writer access.
// Build option FB_WR_FIFO_EN adds a 4-entry {addr,data} write FIFO between writer and RAM.
module fb_arbiter #(
    parameter int unsigned FB_DEPTH = 19200,
    parameter int unsigned ADDR_W   = 15
) (
    input  logic              clk_25,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_data,
    output logic              disp_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              wr_pending,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_wdata,
    input  logic              ram_rdata
);

    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(FB_DEPTH);

    typedef enum logic [0:0] {StIdle, StAck} wr_state_e;

    wr_state_e         state_q, state_d;
    logic              err_q, err_d;
    logic              run_q;
    logic              disp_valid_q, disp_oor_q;
    logic              disp_in_range, wr_in_range;
    logic              ack_c, ram_we_c, ram_wdata_c;
    logic [ADDR_W-1:0] ram_addr_c;

    assign disp_in_range = {1'b0, disp_addr} < DepthLim;
    assign wr_in_range   = {1'b0, wr_addr} < DepthLim;

`ifdef FB_WR_FIFO_EN
    localparam int unsigned FifoDepth = 4;

    logic [ADDR_W-1:0]    fifo_addr_q [FifoDepth];
    logic [FifoDepth-1:0] fifo_data_q;
    logic [1:0]           rd_ptr_q, wr_ptr_q;
    logic [2:0]           count_q;
    logic                 push, pop, fifo_full;

    assign fifo_full = (count_q == 3'd4);
`endif

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        ack_c       = 1'b0;
        ram_we_c    = 1'b0;
        ram_wdata_c = 1'b0;
        ram_addr_c  = '0;
`ifdef FB_WR_FIFO_EN
        push        = 1'b0;
        pop         = 1'b0;
`endif
        if (disp_req) begin
            ram_addr_c = disp_in_range ? disp_addr : '0;
        end

        case (state_q)
            StIdle: begin
`ifdef FB_WR_FIFO_EN
                // Out-of-range writes are acked with wr_err but never enqueued.
                if (wr_req && !fifo_full) begin
                    state_d = StAck;
                    err_d   = !wr_in_range;
                    push    = wr_in_range;
                end
`else
                // run_q keeps the first cycle after reset free of RAM writes.
                if (wr_req && !disp_req && run_q) begin
                    state_d = StAck;
                    err_d   = !wr_in_range;
                    if (wr_in_range) begin
                        ram_we_c    = 1'b1;
                        ram_addr_c  = wr_addr;
                        ram_wdata_c = wr_data;
                    end
                end
`endif
            end
            StAck: begin
                state_d = StIdle;
                ack_c   = 1'b1;
            end
            default: state_d = StIdle;
        endcase

`ifdef FB_WR_FIFO_EN
        if (!disp_req && (count_q != 3'd0) && run_q) begin
            pop         = 1'b1;
            ram_we_c    = 1'b1;
            ram_addr_c  = fifo_addr_q[rd_ptr_q];
            ram_wdata_c = fifo_data_q[rd_ptr_q];
        end
`endif
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            err_q        <= 1'b0;
            run_q        <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_oor_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            run_q        <= 1'b1;
            disp_valid_q <= disp_req;
            disp_oor_q   <= disp_req & ~disp_in_range;
        end
    end

`ifdef FB_WR_FIFO_EN
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // Payload storage needs no reset; count_q/pointers define validity.
    always_ff @(posedge clk_25) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_pending = reset_n & (count_q != 3'd0);
`else
    assign wr_pending = 1'b0;
`endif

    // Reset gates the combinational RAM port so every output reads 0 while reset_n=0.
    assign ram_we     = reset_n & ram_we_c;
    assign ram_wdata  = reset_n & ram_wdata_c;
    assign ram_addr   = reset_n ? ram_addr_c : '0;
    assign wr_ack     = reset_n & ack_c;
    assign wr_err     = reset_n & ack_c & err_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q & ~disp_oor_q & ram_rdata;

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter FB_DEPTH, default 19200; number of 1-bit framebuffer locations (160x120).
REQ-002 Parameter ADDR_W, default 15; address width for all address ports.
REQ-003 clk_25  input  1  pixel clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 disp_req  input  1  display read request, driven by the active-video (bright) qualifier.
REQ-006 disp_addr  input  ADDR_W  display read address.
REQ-007 disp_data  output  1  read data returned to the display.
REQ-008 disp_valid  output  1  disp_data is valid this cycle.
REQ-009 wr_req  input  1  writer request; wr_addr and wr_data are held stable until wr_ack.
REQ-010 wr_addr  input  ADDR_W  write address.
REQ-011 wr_data  input  1  write pixel value.
REQ-012 wr_ack  output  1  one-cycle pulse; the current write is accepted.
REQ-013 wr_err  output  1  one-cycle pulse with wr_ack; the write was out of range and was dropped.
REQ-014 wr_pending  output  1  accepted writes are not yet committed to RAM.
REQ-015 ram_addr  output  ADDR_W  single-port RAM address.
REQ-016 ram_we  output  1  RAM write enable.
REQ-017 ram_wdata  output  1  RAM write data.
REQ-018 ram_rdata  input  1  RAM read data; synchronous RAM, one-cycle read latency.

Function
REQ-019 The display has absolute priority: in any cycle with disp_req=1, ram_we=0 and ram_addr=disp_addr.
REQ-020 disp_valid is disp_req registered one cycle; disp_data is ram_rdata when disp_valid=1, otherwise 0.
REQ-021 A display read with disp_addr>=FB_DEPTH drives ram_addr=0, and the matching disp_data is 0.
REQ-022 ram_addr, ram_we and ram_wdata are combinational from the current grant decision; they are 0 when the port is idle.
REQ-023 Writer FSM has states IDLE and ACK.
  - IDLE->ACK on wr_req=1 and disp_req=0 and the write is issued; in-range writes drive ram_we=1 that cycle.
  - ACK->IDLE unconditionally; wr_ack=1 is asserted in ACK.
  - No write is issued while in ACK.
REQ-024 An out-of-range write (wr_addr>=FB_DEPTH) follows the same handshake with ram_we=0, and wr_err=1 coincides with wr_ack.
REQ-025 Simultaneous disp_req and wr_req: the read is served and the write waits, with no limit on the wait.
REQ-026 Address comparison is unsigned against FB_DEPTH; there is no wrap-around on writes.
REQ-027 wr_pending is 0 whenever the FIFO is compiled out.

Reset
REQ-028 While reset_n=0, all outputs are 0, the FSM is IDLE and the FIFO is empty.
REQ-029 Reset asserted mid-operation discards all un-committed writes; no RAM write is issued during or immediately after reset.

Configuration
REQ-030 Macro FB_WR_FIFO_EN.
  - Defined: a 4-entry {addr,data} write FIFO decouples the writer from the RAM.
  - Undefined: writes stall per REQ-023.
REQ-031 With the FIFO, when not full, wr_req is accepted with wr_ack the next cycle regardless of disp_req, and the ACK state still separates accepts.
REQ-032 With the FIFO, the FIFO head commits to RAM in any cycle with disp_req=0, in FIFO order; out-of-range entries are flagged with wr_err at accept and are never enqueued.
REQ-033 With the FIFO, a full FIFO withholds wr_ack; a simultaneous accept and commit on a full FIFO is not permitted (accept waits).
REQ-034 With the FIFO, wr_pending=1 when the FIFO is non-empty.

Verification
REQ-035 disp_req=1 with disp_addr=100 and RAM[100]=1 -> next cycle disp_valid=1 and disp_data=1; ram_we stays 0 throughout.
REQ-036 No FIFO; wr_req with addr=5 and data=1 while disp_req=1 for 10 cycles -> no ram_we for those 10 cycles; ram_we=1 at addr 5 in the first cycle disp_req=0; wr_ack the cycle after.
REQ-037 wr_addr=19200 -> wr_ack=1 and wr_err=1 together; ram_we never asserted.
REQ-038 FIFO build; 5 back-to-back writes during active video -> 4 acks, then ack withheld, wr_pending=1; after disp_req drops, 4 in-order RAM writes, then the 5th is accepted.
REQ-039 reset_n pulsed low with 3 FIFO entries pending -> all outputs 0, wr_pending=0, no subsequent RAM writes of those entries.
REQ-040 disp_addr=20000 -> ram_addr=0 and disp_data=0 on the following cycle.
